// File: rtl/pow_5.sv
// pow_5: three ways of computing n^5 modulo 2^18 from one shared operand.
//   - n_pow_5_comb : purely combinational, zero latency
//   - n_pow_5_pipe : four-stage pipeline, one result per cycle
//   - n_pow_5_seq  : multi-cycle unit with one shared multiplier and a
//                    run/ready handshake
// Every intermediate product is truncated to 18 bits. Because the products
// are assigned to 18-bit signals, only the low 18 bits are kept, which gives
// exactly the modulo-2^18 result.
module pow_5 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [17:0] n,
    output logic        ready,
    output logic [17:0] n_pow_5_seq,
    output logic [17:0] n_pow_5_pipe,
    output logic [17:0] n_pow_5_comb
);

    // ------------------------------------------------------------------
    // Combinational unit
    // ------------------------------------------------------------------
    logic [17:0] comb_sq;
    logic [17:0] comb_cube;
    logic [17:0] comb_p4;

    // Chain of four truncated multiplies; reset has no influence here.
    always_comb begin
        comb_sq      = n * n;
        comb_cube    = comb_sq * n;
        comb_p4      = comb_cube * n;
        n_pow_5_comb = comb_p4 * n;
    end

    // ------------------------------------------------------------------
    // Pipelined unit
    // ------------------------------------------------------------------
    // Each stage carries the operand alongside its partial power so the
    // next stage can multiply by n again without any stall or valid bit.
    logic [17:0] s1_n;
    logic [17:0] s1_pow;
    logic [17:0] s2_n;
    logic [17:0] s2_pow;
    logic [17:0] s3_n;
    logic [17:0] s3_pow;

    // Advance every pipeline stage on each rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_n         <= 18'd0;
            s1_pow       <= 18'd0;
            s2_n         <= 18'd0;
            s2_pow       <= 18'd0;
            s3_n         <= 18'd0;
            s3_pow       <= 18'd0;
            n_pow_5_pipe <= 18'd0;
        end else begin
            s1_n         <= n;
            s1_pow       <= n * n;
            s2_n         <= s1_n;
            s2_pow       <= s1_pow * s1_n;
            s3_n         <= s2_n;
            s3_pow       <= s2_pow * s2_n;
            n_pow_5_pipe <= s3_pow * s3_n;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle unit
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  step_cnt;
    logic [2:0]  step_cnt_next;
    logic [17:0] x;
    logic [17:0] x_next;
    logic [17:0] acc;
    logic [17:0] acc_next;
    logic [17:0] seq_next;
    logic        ready_next;
    logic [17:0] mul_out;

    // The single shared multiplier: the accumulator times the latched operand.
    always_comb begin
        mul_out = acc * x;
    end

    // Next-state logic: a start loads x and acc with n, then four BUSY
    // edges multiply acc by x. The edge on which the counter drops from
    // 1 to 0 publishes the result and pulses ready for one cycle.
    // run is only looked at in IDLE, so requests while BUSY are dropped.
    always_comb begin
        state_next    = state;
        step_cnt_next = step_cnt;
        x_next        = x;
        acc_next      = acc;
        seq_next      = n_pow_5_seq;
        ready_next    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    x_next        = n;
                    acc_next      = n;
                    step_cnt_next = 3'd4;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                acc_next      = mul_out;
                step_cnt_next = step_cnt - 3'd1;
                if (step_cnt == 3'd1) begin
                    state_next = IDLE;
                    seq_next   = mul_out;
                    ready_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers of the multi-cycle unit; reset aborts
    // any computation in flight without a ready pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            step_cnt    <= 3'd0;
            x           <= 18'd0;
            acc         <= 18'd0;
            n_pow_5_seq <= 18'd0;
            ready       <= 1'b0;
        end else begin
            state       <= state_next;
            step_cnt    <= step_cnt_next;
            x           <= x_next;
            acc         <= acc_next;
            n_pow_5_seq <= seq_next;
            ready       <= ready_next;
        end
    end

endmodule

// File: tb/tb_pow_5.sv
// tb_pow_5: randomized and directed checks of all three pow_5 units against
// a behavioural model computed with plain modular arithmetic.
module tb_pow_5;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic [17:0] n;
    logic        ready;
    logic [17:0] n_pow_5_seq;
    logic [17:0] n_pow_5_pipe;
    logic [17:0] n_pow_5_comb;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [17:0] hist[$];
    logic [17:0] exp_pipe;
    logic [17:0] exp_seq;
    logic        exp_ready;
    bit          pending;
    int          edge_no;
    int          due_edge;
    logic [17:0] due_val;

    pow_5 dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .n            (n),
        .ready        (ready),
        .n_pow_5_seq  (n_pow_5_seq),
        .n_pow_5_pipe (n_pow_5_pipe),
        .n_pow_5_comb (n_pow_5_comb)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: v^5 mod 2^18.
    function automatic logic [17:0] pow5(input logic [17:0] v);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < 5; i++) r = (r * longint'(v)) % 64'd262144;
        return r[17:0];
    endfunction

    // Advance one clock edge and update the model; sampling happens 1 unit later.
    task automatic tick();
        logic        run_s;
        logic [17:0] n_s;
        run_s = run;
        n_s   = n;
        @(posedge clock);
        #1;
        edge_no++;
        hist.push_back(n_s);
        exp_pipe  = (hist.size() >= 4) ? pow5(hist[hist.size() - 4]) : 18'd0;
        exp_ready = 1'b0;
        if (!pending && run_s) begin
            pending  = 1'b1;
            due_edge = edge_no + 4;
            due_val  = pow5(n_s);
        end else if (pending && edge_no == due_edge) begin
            pending   = 1'b0;
            exp_ready = 1'b1;
            exp_seq   = due_val;
        end
    endtask

    // Hold reset for two edges, release away from the clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        hist.delete();
        exp_pipe  = 18'd0;
        exp_seq   = 18'd0;
        exp_ready = 1'b0;
        pending   = 1'b0;
        edge_no   = 0;
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        n = 18'd5;
        reset_n = 1'b0;
        #2;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %0b expected 0", ready);
        end
        checks++;
        if (n_pow_5_seq !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_seq: got %0d expected 0", n_pow_5_seq);
        end
        checks++;
        if (n_pow_5_pipe !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_pipe: got %0d expected 0", n_pow_5_pipe);
        end
        checks++;
        if (n_pow_5_comb !== 18'd3125) begin
            errors++;
            $display("[TB] FAIL reset_comb: got %0d expected 3125", n_pow_5_comb);
        end
        do_reset();
    endtask

    task automatic test_comb_sweep();
        int table_v[8] = '{0, 1, 32, 243, 1024, 3125, 7776, 16807};
        for (int i = 0; i < 8; i++) begin
            n = 18'(i);
            #1;
            checks++;
            if (n_pow_5_comb !== 18'(table_v[i])) begin
                errors++;
                $display("[TB] FAIL comb_sweep n=%0d: got %0d expected %0d", i, n_pow_5_comb, table_v[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            n = 18'($urandom);
            #1;
            checks++;
            if (n_pow_5_comb !== pow5(n)) begin
                errors++;
                $display("[TB] FAIL comb_random n=%0d: got %0d expected %0d", n, n_pow_5_comb, pow5(n));
            end
        end
    endtask

    task automatic test_pipeline();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            n = (i < 20) ? 18'(i & 7) : 18'($urandom);
            tick();
            checks++;
            if (n_pow_5_pipe !== exp_pipe) begin
                errors++;
                $display("[TB] FAIL pipe cycle %0d: got %0d expected %0d", i, n_pow_5_pipe, exp_pipe);
            end
        end
    endtask

    task automatic test_seq_handshake();
        int pulses;
        int first_edge;
        do_reset();
        pulses     = 0;
        first_edge = -1;
        run = 1'b1;
        n   = 18'd3;
        tick();
        run = 1'b0;
        n   = 18'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready === 1'b1) begin
                pulses++;
                if (first_edge < 0) first_edge = edge_no;
            end
        end
        checks++;
        if (pulses != 1 || first_edge != 5) begin
            errors++;
            $display("[TB] FAIL seq_first_pulse: got %0d pulses at edge %0d expected 1 at edge 5", pulses, first_edge);
        end
        checks++;
        if (n_pow_5_seq !== 18'd243) begin
            errors++;
            $display("[TB] FAIL seq_first_value: got %0d expected 243", n_pow_5_seq);
        end
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = 18'(i & 7);
            tick();
            checks++;
            if (ready !== exp_ready || n_pow_5_seq !== exp_seq) begin
                errors++;
                $display("[TB] FAIL seq_b2b cycle %0d: got ready=%0b seq=%0d expected ready=%0b seq=%0d",
                         i, ready, n_pow_5_seq, exp_ready, exp_seq);
            end
            run = ready;
        end
        run = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int dut_pulses;
        int exp_pulses;
        do_reset();
        dut_pulses = 0;
        exp_pulses = 0;
        run = 1'b1;
        for (int i = 0; i < 41; i++) begin
            n = 18'($urandom);
            tick();
            if (ready === 1'b1) dut_pulses++;
            if (exp_ready) exp_pulses++;
            checks++;
            if (ready !== exp_ready || n_pow_5_seq !== exp_seq) begin
                errors++;
                $display("[TB] FAIL busy cycle %0d: got ready=%0b seq=%0d expected ready=%0b seq=%0d",
                         i, ready, n_pow_5_seq, exp_ready, exp_seq);
            end
        end
        checks++;
        if (dut_pulses != exp_pulses) begin
            errors++;
            $display("[TB] FAIL busy_pulse_count: got %0d expected %0d", dut_pulses, exp_pulses);
        end
        run = 1'b0;
    endtask

    task automatic test_wrap();
        logic [17:0] vals[2] = '{18'd13, 18'd12};
        logic [17:0] want[2] = '{18'd109149, 18'd248832};
        bit seen;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            n    = vals[k];
            run  = 1'b1;
            seen = 1'b0;
            #1;
            checks++;
            if (n_pow_5_comb !== want[k]) begin
                errors++;
                $display("[TB] FAIL wrap_comb n=%0d: got %0d expected %0d", n, n_pow_5_comb, want[k]);
            end
            tick();
            run = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                tick();
                if (ready === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || n_pow_5_seq !== want[k]) begin
                errors++;
                $display("[TB] FAIL wrap_seq n=%0d: got ready_seen=%0b seq=%0d expected %0d", n, seen, n_pow_5_seq, want[k]);
            end
            checks++;
            if (n_pow_5_pipe !== want[k]) begin
                errors++;
                $display("[TB] FAIL wrap_pipe n=%0d: got %0d expected %0d", n, n_pow_5_pipe, want[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        n   = 18'd2;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n   = 18'd9;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || n_pow_5_seq !== 18'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got ready=%0b seq=%0d expected ready=0 seq=0", ready, n_pow_5_seq);
        end
        checks++;
        if (n_pow_5_comb !== 18'd59049) begin
            errors++;
            $display("[TB] FAIL midreset_comb: got %0d expected 59049", n_pow_5_comb);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || n_pow_5_seq !== 18'd0) begin
            errors++;
            $display("[TB] FAIL midreset_hold: got ready_seen=%0b seq=%0d expected no pulse seq=0", seen, n_pow_5_seq);
        end
        do_reset();
        n   = 18'd7;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ready !== exp_ready || n_pow_5_seq !== exp_seq) begin
                errors++;
                $display("[TB] FAIL midreset_rerun cycle %0d: got ready=%0b seq=%0d expected ready=%0b seq=%0d",
                         i, ready, n_pow_5_seq, exp_ready, exp_seq);
            end
        end
        checks++;
        if (n_pow_5_seq !== 18'd16807) begin
            errors++;
            $display("[TB] FAIL midreset_result: got %0d expected 16807", n_pow_5_seq);
        end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        n         = 18'd0;
        pending   = 1'b0;
        edge_no   = 0;
        exp_pipe  = 18'd0;
        exp_seq   = 18'd0;
        exp_ready = 1'b0;
        test_reset();
        test_comb_sweep();
        test_pipeline();
        test_seq_handshake();
        test_busy_ignore();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
